// File: rtl/noc_if.sv
// Credit-based, per-VC link between a NoC tree leaf port and its client endpoint.
// Packet layout is {addr, data}; vc_target and vc_credit_gnt are one-hot per VC.
interface noc_if #(
   parameter int A_W  = 3,
   parameter int D_W  = 8,
   parameter int VC_W = 2
) ();
   logic [VC_W-1:0]    vc_target;
   logic [A_W+D_W-1:0] packet;
   logic [VC_W-1:0]    vc_credit_gnt;

   modport transmitter (output vc_target, output packet, input vc_credit_gnt);
   modport receiver    (input vc_target, input packet, output vc_credit_gnt);
endinterface

// File: rtl/noc_leaf_endpoint.sv
// Client endpoint for one NoC leaf: credit-gated TX towards the tree, per-VC RX FIFOs with round-robin drain.
// Optional flit counters are built when NOC_LEAF_ENDPOINT_STATS_EN is defined.
module noc_leaf_endpoint #(
   parameter int N             = 4,
   parameter int VC_W          = 2,
   parameter int D_W           = 8,
   parameter int VC_FIFO_DEPTH = 4,
   localparam int A_W          = $clog2(N) + 1,
   localparam int VCI_W        = (VC_W > 1) ? $clog2(VC_W) : 1
) (
   input  logic             clk,
   input  logic             rst,
   noc_if.transmitter       noc_tx,
   noc_if.receiver          noc_rx,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [VCI_W-1:0] req_vc,
   input  logic [A_W-1:0]   req_addr,
   input  logic [D_W-1:0]   req_data,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [VCI_W-1:0] rsp_vc,
   output logic [A_W-1:0]   rsp_addr,
   output logic [D_W-1:0]   rsp_data,
   output logic             err_overflow,
   output logic [31:0]      tx_count,
   output logic [31:0]      rx_count
);
   localparam int CR_W  = $clog2(VC_FIFO_DEPTH);
   localparam int F     = VC_FIFO_DEPTH - 1;
   localparam int PTR_W = (F > 1) ? $clog2(F) : 1;
   localparam int CNT_W = $clog2(F + 1);
   localparam int PW    = A_W + D_W;
   localparam logic [CR_W-1:0]  CR_MAX   = CR_W'(F);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(F);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(F - 1);

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   logic [CR_W-1:0] credit [VC_W];
   logic [VC_W-1:0] credit_nz;
   logic [VC_W-1:0] req_sel;
   logic [VC_W-1:0] take_vc;
   logic            accept;

   always_comb begin
      credit_nz = '0;
      for (int v = 0; v < VC_W; v++) credit_nz[v] = (credit[v] != '0);
   end

   // An out-of-range req_vc shifts out to an empty select and is never ready.
   assign req_sel   = VC_W'(1) << req_vc;
   assign req_ready = |(req_sel & credit_nz);
   assign accept    = req_valid && req_ready;
   assign take_vc   = accept ? req_sel : '0;

   always_ff @(posedge clk) begin
      if (!rst) begin
         noc_tx.vc_target <= '0;
         noc_tx.packet    <= '0;
         for (int v = 0; v < VC_W; v++) credit[v] <= CR_MAX;
      end else begin
         noc_tx.vc_target <= take_vc;
         if (accept) noc_tx.packet <= {req_addr, req_data};
         for (int v = 0; v < VC_W; v++) begin
            if (take_vc[v] && !noc_tx.vc_credit_gnt[v])
               credit[v] <= credit[v] - CR_W'(1);
            else if (noc_tx.vc_credit_gnt[v] && !take_vc[v] && (credit[v] != CR_MAX))
               credit[v] <= credit[v] + CR_W'(1);
         end
      end
   end

   logic [PW-1:0]    mem [VC_W][F];
   logic [PTR_W-1:0] wr_ptr [VC_W];
   logic [PTR_W-1:0] rd_ptr [VC_W];
   logic [CNT_W-1:0] cnt [VC_W];
   logic [VC_W-1:0]  wr_sel;
   logic [VC_W-1:0]  wr_ok;
   logic [VC_W-1:0]  nonempty;
   logic [VC_W-1:0]  pop_vc;
   logic [VCI_W-1:0] rr_ptr;
   logic [VCI_W-1:0] gnt_idx;
   logic [VCI_W-1:0] next_vc;
   logic [PW-1:0]    head;
   logic             pop;

   // Isolate the lowest set bit so a malformed multi-hot target writes one FIFO only.
   assign wr_sel = noc_rx.vc_target & (~noc_rx.vc_target + VC_W'(1));

   always_comb begin
      nonempty = '0;
      for (int v = 0; v < VC_W; v++) nonempty[v] = (cnt[v] != '0);
   end

   always_comb begin : arb
      logic [VCI_W-1:0] cand;
      cand      = '0;
      gnt_idx   = '0;
      rsp_valid = 1'b0;
      for (int i = 0; i < VC_W; i++) begin
         cand = VCI_W'((int'(rr_ptr) + i) % VC_W);
         if (!rsp_valid && nonempty[cand]) begin
            rsp_valid = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   assign pop     = rsp_valid && rsp_ready;
   assign pop_vc  = pop ? (VC_W'(1) << gnt_idx) : '0;
   assign next_vc = (gnt_idx == VCI_W'(VC_W - 1)) ? '0 : gnt_idx + VCI_W'(1);
   assign head    = mem[gnt_idx][rd_ptr[gnt_idx]];

   assign rsp_vc   = rsp_valid ? gnt_idx : '0;
   assign rsp_addr = rsp_valid ? head[PW-1:D_W] : '0;
   assign rsp_data = rsp_valid ? head[D_W-1:0] : '0;

   // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
   always_comb begin
      wr_ok = '0;
      for (int v = 0; v < VC_W; v++)
         wr_ok[v] = wr_sel[v] && ((cnt[v] != CNT_FULL) || pop_vc[v]);
   end

   always_ff @(posedge clk) begin
      for (int v = 0; v < VC_W; v++)
         if (wr_ok[v]) mem[v][wr_ptr[v]] <= noc_rx.packet;
   end

   // While stalled the pointer parks on the granted VC, so a later arrival cannot steal the head.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int v = 0; v < VC_W; v++) begin
            wr_ptr[v] <= '0;
            rd_ptr[v] <= '0;
            cnt[v]    <= '0;
         end
         rr_ptr               <= '0;
         err_overflow         <= 1'b0;
         noc_rx.vc_credit_gnt <= '0;
      end else begin
         for (int v = 0; v < VC_W; v++) begin
            if (wr_ok[v]) wr_ptr[v] <= next_ptr(wr_ptr[v]);
            if (pop_vc[v]) rd_ptr[v] <= next_ptr(rd_ptr[v]);
            if (wr_ok[v] && !pop_vc[v]) cnt[v] <= cnt[v] + CNT_W'(1);
            else if (pop_vc[v] && !wr_ok[v]) cnt[v] <= cnt[v] - CNT_W'(1);
         end
         if (|(wr_sel & ~wr_ok)) err_overflow <= 1'b1;
         noc_rx.vc_credit_gnt <= pop_vc;
         if (pop) rr_ptr <= next_vc;
         else if (rsp_valid) rr_ptr <= gnt_idx;
      end
   end

`ifdef NOC_LEAF_ENDPOINT_STATS_EN
   logic [31:0] tx_cnt_q;
   logic [31:0] rx_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         tx_cnt_q <= '0;
         rx_cnt_q <= '0;
      end else begin
         if (accept) tx_cnt_q <= tx_cnt_q + 32'd1;
         if (pop) rx_cnt_q <= rx_cnt_q + 32'd1;
      end
   end

   assign tx_count = tx_cnt_q;
   assign rx_count = rx_cnt_q;
`else
   assign tx_count = '0;
   assign rx_count = '0;
`endif
endmodule

// File: tb/tb_noc_leaf_endpoint.sv
// Directed bench for noc_leaf_endpoint: credits, RX arbitration, backpressure, overflow, reset and stats.
module tb_noc_leaf_endpoint;
   localparam int N = 4;
   localparam int VC_W = 2;
   localparam int D_W = 8;
   localparam int VC_FIFO_DEPTH = 4;
   localparam int A_W = $clog2(N) + 1;
   localparam int VCI_W = 1;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             req_valid;
   logic             req_ready;
   logic [VCI_W-1:0] req_vc;
   logic [A_W-1:0]   req_addr;
   logic [D_W-1:0]   req_data;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [VCI_W-1:0] rsp_vc;
   logic [A_W-1:0]   rsp_addr;
   logic [D_W-1:0]   rsp_data;
   logic             err_overflow;
   logic [31:0]      tx_count;
   logic [31:0]      rx_count;

   int checks = 0;
   int errors = 0;

   noc_if #(.A_W(A_W), .D_W(D_W), .VC_W(VC_W)) tx_if ();
   noc_if #(.A_W(A_W), .D_W(D_W), .VC_W(VC_W)) rx_if ();

   noc_leaf_endpoint #(
      .N(N), .VC_W(VC_W), .D_W(D_W), .VC_FIFO_DEPTH(VC_FIFO_DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .noc_tx(tx_if), .noc_rx(rx_if),
      .req_valid(req_valid), .req_ready(req_ready), .req_vc(req_vc),
      .req_addr(req_addr), .req_data(req_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_vc(rsp_vc),
      .rsp_addr(rsp_addr), .rsp_data(rsp_data),
      .err_overflow(err_overflow), .tx_count(tx_count), .rx_count(rx_count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req_valid = 1'b0;
      req_vc = '0;
      req_addr = '0;
      req_data = '0;
      rsp_ready = 1'b0;
      tx_if.vc_credit_gnt = '0;
      rx_if.vc_target = '0;
      rx_if.packet = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b0;
      step();
      step();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({tx_if.vc_target, rx_if.vc_credit_gnt} !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL reset_targets got %b want 0000", {tx_if.vc_target, rx_if.vc_credit_gnt});
      end
      checks++;
      if ({rsp_valid, err_overflow, rsp_addr, rsp_data} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_rsp got %h want 0", {rsp_valid, err_overflow, rsp_addr, rsp_data});
      end
      checks++;
      if ({tx_count, rx_count} !== 64'd0) begin
         errors++;
         $display("[TB] FAIL reset_counts got %0d/%0d want 0/0", tx_count, rx_count);
      end
      for (int v = 0; v < VC_W; v++) begin
         req_vc = VCI_W'(v);
         #1;
         checks++;
         if (req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready vc%0d got %b want 1", v, req_ready);
         end
      end
      req_vc = '0;
   endtask

   task automatic test_credit_exhaustion();
      logic [A_W+D_W-1:0] exp_pkt;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         req_valid = 1'b1;
         req_vc = 1'b0;
         req_addr = A_W'(i + 1);
         req_data = D_W'(8'hA0 + i);
         exp_pkt = {A_W'(i + 1), D_W'(8'hA0 + i)};
         #1;
         checks++;
         if (req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL exhaust_ready%0d got %b want 1", i, req_ready);
         end
         step();
         checks++;
         if (tx_if.vc_target !== 2'b01 || tx_if.packet !== exp_pkt) begin
            errors++;
            $display("[TB] FAIL exhaust_tx%0d got %b/%h want 01/%h", i, tx_if.vc_target, tx_if.packet, exp_pkt);
         end
      end
      req_addr = 3'd4;
      req_data = 8'hA3;
      #1;
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL exhaust_ready3 got %b want 0", req_ready);
      end
      step();
      checks++;
      if (tx_if.vc_target !== 2'b00) begin
         errors++;
         $display("[TB] FAIL exhaust_idle got %b want 00", tx_if.vc_target);
      end
      req_vc = 1'b1;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL exhaust_vc1_ready got %b want 1", req_ready);
      end
      step();
      req_valid = 1'b0;
      checks++;
      if (tx_if.vc_target !== 2'b10) begin
         errors++;
         $display("[TB] FAIL exhaust_vc1_tx got %b want 10", tx_if.vc_target);
      end
   endtask

   // Continues from the exhausted state: VC0 has no credit left.
   task automatic test_credit_return();
      req_valid = 1'b0;
      req_vc = 1'b0;
      tx_if.vc_credit_gnt = 2'b01;
      #1;
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL return_ready_t got %b want 0", req_ready);
      end
      step();
      tx_if.vc_credit_gnt = 2'b00;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL return_ready_t1 got %b want 1", req_ready);
      end
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      checks++;
      if (tx_if.vc_target !== 2'b01) begin
         errors++;
         $display("[TB] FAIL return_tx_t2 got %b want 01", tx_if.vc_target);
      end
      tx_if.vc_credit_gnt = 2'b01;
      step();
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      tx_if.vc_credit_gnt = 2'b00;
      #1;
      checks++;
      if (tx_if.vc_target !== 2'b01 || req_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL return_same_cycle got %b/%b want 01/1", tx_if.vc_target, req_ready);
      end
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      #1;
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL return_credit_one got %b want 0", req_ready);
      end
   endtask

   task automatic test_rx_round_robin();
      logic [1:0] exp_gnt;
      do_reset();
      rsp_ready = 1'b1;
      for (int k = 0; k <= 4; k++) begin
         rx_if.vc_target = (k < 4) ? (2'b01 << (k % 2)) : 2'b00;
         rx_if.packet = {A_W'(k), D_W'(8'hC0 + k)};
         step();
         exp_gnt = (k > 0) ? (2'b01 << ((k - 1) % 2)) : 2'b00;
         checks++;
         if (rx_if.vc_credit_gnt !== exp_gnt) begin
            errors++;
            $display("[TB] FAIL rr_gnt%0d got %b want %b", k, rx_if.vc_credit_gnt, exp_gnt);
         end
         if (k < 4) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_vc !== VCI_W'(k % 2) || rsp_addr !== A_W'(k) || rsp_data !== D_W'(8'hC0 + k)) begin
               errors++;
               $display("[TB] FAIL rr_rsp%0d got %b/%0d/%h/%h want 1/%0d/%h/%h", k, rsp_valid, rsp_vc, rsp_addr, rsp_data, k % 2, k, 8'hC0 + k);
            end
         end else begin
            checks++;
            if (rsp_valid !== 1'b0) begin
               errors++;
               $display("[TB] FAIL rr_drained got %b want 0", rsp_valid);
            end
         end
      end
      step();
      checks++;
      if (rx_if.vc_credit_gnt !== 2'b00) begin
         errors++;
         $display("[TB] FAIL rr_gnt_end got %b want 00", rx_if.vc_credit_gnt);
      end
      rsp_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      do_reset();
      rx_if.vc_target = 2'b10;
      rx_if.packet = {3'd5, 8'h5A};
      step();
      rx_if.vc_target = 2'b01;
      rx_if.packet = {3'd6, 8'h6B};
      for (int j = 0; j < 5; j++) begin
         if (j > 0) rx_if.vc_target = 2'b00;
         #1;
         checks++;
         if (rsp_valid !== 1'b1 || rsp_vc !== 1'b1 || rsp_addr !== 3'd5 || rsp_data !== 8'h5A || rx_if.vc_credit_gnt !== 2'b00) begin
            errors++;
            $display("[TB] FAIL bp_hold%0d got %b/%0d/%h/%h/%b want 1/1/5/5a/00", j, rsp_valid, rsp_vc, rsp_addr, rsp_data, rx_if.vc_credit_gnt);
         end
         step();
      end
      rsp_ready = 1'b1;
      step();
      checks++;
      if (rsp_vc !== 1'b0 || rsp_data !== 8'h6B || rx_if.vc_credit_gnt !== 2'b10) begin
         errors++;
         $display("[TB] FAIL bp_release got %0d/%h/%b want 0/6b/10", rsp_vc, rsp_data, rx_if.vc_credit_gnt);
      end
      step();
      checks++;
      if (rsp_valid !== 1'b0 || rx_if.vc_credit_gnt !== 2'b01) begin
         errors++;
         $display("[TB] FAIL bp_drain got %b/%b want 0/01", rsp_valid, rx_if.vc_credit_gnt);
      end
      rsp_ready = 1'b0;
   endtask

   task automatic test_overflow();
      do_reset();
      for (int k = 0; k < 4; k++) begin
         rx_if.vc_target = 2'b01;
         rx_if.packet = {A_W'(k), D_W'(8'h70 + k)};
         step();
         checks++;
         if (err_overflow !== (k == 3)) begin
            errors++;
            $display("[TB] FAIL ovf_flag%0d got %b want %b", k, err_overflow, k == 3);
         end
      end
      rx_if.vc_target = 2'b00;
      rsp_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (rsp_valid !== 1'b1 || rsp_addr !== A_W'(k) || rsp_data !== D_W'(8'h70 + k)) begin
            errors++;
            $display("[TB] FAIL ovf_pop%0d got %b/%h/%h want 1/%h/%h", k, rsp_valid, rsp_addr, rsp_data, k, 8'h70 + k);
         end
         step();
      end
      checks++;
      if (rsp_valid !== 1'b0 || err_overflow !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ovf_end got %b/%b want 0/1", rsp_valid, err_overflow);
      end
      rsp_ready = 1'b0;
   endtask

   task automatic test_full_write_pop();
      do_reset();
      for (int k = 0; k < 3; k++) begin
         rx_if.vc_target = 2'b01;
         rx_if.packet = {3'd1, D_W'(8'h80 + k)};
         step();
      end
      rx_if.packet = {3'd1, 8'h83};
      rsp_ready = 1'b1;
      #1;
      checks++;
      if (rsp_data !== 8'h80) begin
         errors++;
         $display("[TB] FAIL fwp_head got %h want 80", rsp_data);
      end
      step();
      rx_if.vc_target = 2'b00;
      for (int k = 1; k <= 3; k++) begin
         #1;
         checks++;
         if (rsp_valid !== 1'b1 || rsp_data !== D_W'(8'h80 + k) || err_overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fwp_pop%0d got %b/%h/%b want 1/%h/0", k, rsp_valid, rsp_data, err_overflow, 8'h80 + k);
         end
         step();
      end
      rsp_ready = 1'b0;
   endtask

   task automatic test_multi_hot();
      do_reset();
      rx_if.vc_target = 2'b11;
      rx_if.packet = {3'd2, 8'h99};
      step();
      rx_if.vc_target = 2'b00;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_vc !== 1'b0 || rsp_data !== 8'h99) begin
         errors++;
         $display("[TB] FAIL mh_rsp got %b/%0d/%h want 1/0/99", rsp_valid, rsp_vc, rsp_data);
      end
      rsp_ready = 1'b1;
      step();
      checks++;
      if (rsp_valid !== 1'b0 || rx_if.vc_credit_gnt !== 2'b01) begin
         errors++;
         $display("[TB] FAIL mh_single got %b/%b want 0/01", rsp_valid, rx_if.vc_credit_gnt);
      end
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset_stats();
      logic [31:0] exp_cnt;
`ifdef NOC_LEAF_ENDPOINT_STATS_EN
      exp_cnt = 32'd10;
`else
      exp_cnt = 32'd0;
`endif
      do_reset();
      rsp_ready = 1'b1;
      for (int i = 0; i <= 10; i++) begin
         req_valid = (i < 10);
         req_vc = VCI_W'(i % 2);
         req_addr = A_W'(i);
         req_data = D_W'(i);
         tx_if.vc_credit_gnt = (i > 0) ? (2'b01 << ((i - 1) % 2)) : 2'b00;
         rx_if.vc_target = (i < 10) ? (2'b01 << (i % 2)) : 2'b00;
         rx_if.packet = {A_W'(i), D_W'(8'h40 + i)};
         #1;
         if (i < 10) begin
            checks++;
            if (req_ready !== 1'b1) begin
               errors++;
               $display("[TB] FAIL stats_ready%0d got %b want 1", i, req_ready);
            end
         end
         step();
      end
      idle_inputs();
      step();
      checks++;
      if (tx_count !== exp_cnt || rx_count !== exp_cnt) begin
         errors++;
         $display("[TB] FAIL stats_counts got %0d/%0d want %0d/%0d", tx_count, rx_count, exp_cnt, exp_cnt);
      end
      for (int k = 0; k < 4; k++) begin
         rx_if.vc_target = 2'b01;
         rx_if.packet = {A_W'(k), 8'hEE};
         step();
      end
      rx_if.vc_target = 2'b00;
      checks++;
      if (err_overflow !== 1'b1 || rsp_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL stats_prereset got %b/%b want 1/1", err_overflow, rsp_valid);
      end
      req_valid = 1'b1;
      req_vc = 1'b0;
      rst = 1'b0;
      step();
      rst = 1'b1;
      req_valid = 1'b0;
      #1;
      checks++;
      if ({tx_if.vc_target, rx_if.vc_credit_gnt, rsp_valid, err_overflow, rsp_addr, rsp_data} !== '0) begin
         errors++;
         $display("[TB] FAIL stats_postreset got %h want 0", {tx_if.vc_target, rx_if.vc_credit_gnt, rsp_valid, err_overflow, rsp_addr, rsp_data});
      end
      checks++;
      if ({tx_count, rx_count} !== 64'd0) begin
         errors++;
         $display("[TB] FAIL stats_cleared got %0d/%0d want 0/0", tx_count, rx_count);
      end
      req_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (req_ready !== (i < 3)) begin
            errors++;
            $display("[TB] FAIL stats_credit%0d got %b want %b", i, req_ready, i < 3);
         end
         step();
      end
      req_valid = 1'b0;
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_credit_exhaustion();
      test_credit_return();
      test_rx_round_robin();
      test_backpressure();
      test_overflow();
      test_full_write_pop();
      test_multi_hot();
      test_reset_stats();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog got timeout want completion");
      $fatal(1, "[TB] simulation did not complete");
   end
endmodule
